rng_out_buffer: RTL
===================

RNG_OUT_BUFFER -- requirements
Module: rng_out_buffer

Interface
REQ-001 SHALL have parameter BLOCK_BITS, default 128: width of a DRBG output block.
REQ-002 SHALL have parameter OUT_BITS, default 32: host word width; BLOCK_BITS divisible by OUT_BITS.
REQ-003 SHALL have parameter DEPTH, default 4: FIFO capacity in blocks, power of two, minimum 2.
REQ-004 SHALL have parameter LOW_WATER, default 1: refill threshold in blocks, less than DEPTH.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset: asynchronous, active-low.
REQ-007 enable_i  in  1  level: auto-refill permitted.
REQ-008 blk_valid_i  in  1  one-cycle strobe: blk_data_i valid (from DRBG random_valid_o).
REQ-009 blk_data_i  in  BLOCK_BITS  random block.
REQ-010 drbg_busy_i  in  1  DRBG not idle.
REQ-011 drbg_done_i  in  1  one-cycle DRBG operation-complete strobe.
REQ-012 gen_req_o  out  1  one-cycle generate command to DRBG.
REQ-013 gen_blocks_o  out  16  block count for gen_req_o; zero-extended.
REQ-014 out_valid_o  out  1  out_data_o valid.
REQ-015 out_data_o  out  OUT_BITS  random word.
REQ-016 out_ready_i  in  1  consumer accepts word when high with out_valid_o.
REQ-017 flush_i  in  1  one-cycle strobe: discard all buffered data.
REQ-018 clr_ovf_i  in  1  one-cycle strobe: clear overflow_o.
REQ-019 level_o  out  $clog2(DEPTH)+1  blocks held, including partially-read block.
REQ-020 overflow_o  out  1  sticky: a block was dropped.

Function
REQ-021 Push: blk_valid_i while not full, or full with last-word pop same cycle, SHALL store the block; visible on out_valid_o the next cycle.
REQ-022 blk_valid_i while full and no same-cycle pop SHALL drop the block and set overflow_o the next cycle.
REQ-023 out_valid_o SHALL be high exactly when level_o is nonzero; out_data_o SHALL be word index w of head block, bits [w*OUT_BITS +: OUT_BITS], w starting 0 (LSW first).
REQ-024 Each out_valid_o&&out_ready_i SHALL advance w; the transfer of word BLOCK_BITS/OUT_BITS-1 SHALL pop the head block and reset w to 0.
REQ-025 out_data_o SHALL hold stable while out_valid_o high and out_ready_i low.
REQ-026 level_o SHALL update the cycle after push/pop; simultaneous push and pop leave it unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH; full = level DEPTH, empty = level 0.
REQ-028 Refill FSM states SHALL be R_IDLE, R_REQ, R_WAIT.
REQ-029 R_IDLE -> R_REQ when enable_i && level_o <= LOW_WATER && !drbg_busy_i.
REQ-030 R_REQ SHALL assert gen_req_o for exactly one cycle with gen_blocks_o = DEPTH - level_o sampled that cycle, then go to R_WAIT.
REQ-031 R_WAIT -> R_IDLE on drbg_done_i; enable_i deassertion SHALL NOT abort R_WAIT.
REQ-032 flush_i SHALL empty FIFO, zero w and level_o next cycle; a same-cycle push is discarded without setting overflow; FSM state unaffected.
REQ-033 clr_ovf_i SHALL clear overflow_o; simultaneous drop and clear SHALL leave overflow_o set.

Reset
REQ-034 Reset SHALL force: FSM R_IDLE, pointers/w/level_o 0, out_valid_o 0, gen_req_o 0, gen_blocks_o 0, overflow_o 0, out_data_o 0.
REQ-035 Reset mid-operation SHALL discard buffered blocks and outstanding request state; no gen_req_o within the first cycle after release.

Structure
REQ-036 Package rng_pkg SHALL hold refill-state enum and default parameter constants.
REQ-037 Block storage SHALL be sub-module rng_block_fifo (sync FIFO, push/pop/flush, count); serializer and FSM in rng_out_buffer.

Verification
REQ-038 Empty, enable_i=1, busy=0 -> gen_req_o one pulse, gen_blocks_o=4; no second pulse before drbg_done_i.
REQ-039 Push block 0x000..03_000..02_000..01_000..00 (words 3,2,1,0), out_ready_i=1 -> words 0x0,0x1,0x2,0x3 on consecutive cycles, then out_valid_o=0, level_o 1->0.
REQ-040 Fill 4 blocks, ready=0, push 5th -> dropped, overflow_o=1, level_o=4; clr_ovf_i -> overflow_o=0.
REQ-041 Full, w=3, ready=1 and blk_valid_i same cycle -> block accepted, level_o stays 4, overflow_o=0.
REQ-042 Level 3, w=2, flush_i -> next cycle level_o=0, out_valid_o=0; next push reads from w=0.
REQ-043 Assert rst_n low while R_WAIT with 2 blocks -> all outputs at reset values; refill restarts after release.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and default sizing for the RNG output buffer.
// Refill-state encoding lives here so other blocks can observe it.
package rng_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } refill_e;

  localparam int RNG_BLOCK_BITS = 128;
  localparam int RNG_OUT_BITS   = 32;
  localparam int RNG_DEPTH      = 4;
  localparam int RNG_LOW_WATER  = 1;

endpackage

// File: rtl/rng_block_fifo.sv
// Synchronous block FIFO with flush and occupancy count.
// Caller guarantees push only when not full (or with a same-cycle pop).
module rng_block_fifo
  import rng_pkg::*;
#(
  parameter int W     = RNG_BLOCK_BITS,
  parameter int DEPTH = RNG_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  assign head_o  = mem[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);

  // Next pointers and count; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Block storage; contents are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rng_out_buffer.sv
// Buffers DRBG blocks and serializes them LSW-first to the host.
// Requests a refill from the DRBG when occupancy is low.
module rng_out_buffer
  import rng_pkg::*;
#(
  parameter int BLOCK_BITS = RNG_BLOCK_BITS,
  parameter int OUT_BITS   = RNG_OUT_BITS,
  parameter int DEPTH      = RNG_DEPTH,
  parameter int LOW_WATER  = RNG_LOW_WATER
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    blk_valid_i,
  input  logic [BLOCK_BITS-1:0]   blk_data_i,
  input  logic                    drbg_busy_i,
  input  logic                    drbg_done_i,
  output logic                    gen_req_o,
  output logic [15:0]             gen_blocks_o,
  output logic                    out_valid_o,
  output logic [OUT_BITS-1:0]     out_data_o,
  input  logic                    out_ready_i,
  input  logic                    flush_i,
  input  logic                    clr_ovf_i,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overflow_o
);

  localparam int WORDS = BLOCK_BITS / OUT_BITS;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [WW-1:0] W_LAST = WW'(WORDS - 1);

  logic [BLOCK_BITS-1:0] head;
  logic [LW-1:0]         count;
  logic                  full;
  logic                  fire;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [WW-1:0]         w_q, w_d;
  logic                  ovf_q, ovf_d;
  refill_e               st_q, st_d;
  logic [OUT_BITS-1:0]   words [WORDS];

  rng_block_fifo #(
    .W     (BLOCK_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_i  (blk_data_i),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );

  for (genvar i = 0; i < WORDS; i++) begin : g_words
    assign words[i] = head[i*OUT_BITS +: OUT_BITS];
  end

  assign level_o     = count;
  assign overflow_o  = ovf_q;
  assign out_valid_o = count != '0;
  assign out_data_o  = out_valid_o ? words[w_q] : '0;

  assign fire = out_valid_o && out_ready_i;
  assign pop  = fire && (w_q == W_LAST) && !flush_i;
  assign push = blk_valid_i && (!full || pop) && !flush_i;
  assign drop = blk_valid_i && full && !pop && !flush_i;

  // Word index advance and sticky overflow update.
  always_comb begin
    w_d = w_q;
    if (flush_i) begin
      w_d = '0;
    end else if (fire) begin
      w_d = (w_q == W_LAST) ? '0 : w_q + 1'b1;
    end
    ovf_d = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  // Refill sequencer: one generate command, then wait for completion.
  always_comb begin
    st_d         = st_q;
    gen_req_o    = 1'b0;
    gen_blocks_o = '0;
    unique case (st_q)
      R_IDLE: begin
        if (enable_i && count <= LW'(LOW_WATER) && !drbg_busy_i)
          st_d = R_REQ;
      end
      R_REQ: begin
        gen_req_o    = 1'b1;
        gen_blocks_o = 16'(DEPTH) - 16'(count);
        st_d         = R_WAIT;
      end
      R_WAIT: begin
        if (drbg_done_i) st_d = R_IDLE;
      end
      default: st_d = R_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      ovf_q <= 1'b0;
      st_q  <= R_IDLE;
    end else begin
      w_q   <= w_d;
      ovf_q <= ovf_d;
      st_q  <= st_d;
    end
  end

endmodule
